// File: rtl/serial_link_pkg.sv
// serial_link_pkg: encodings, line levels and default geometry shared by the
// transmit and receive sides of the serial character link.
package serial_link_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;
   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;
   localparam int DEF_DATA_BITS    = 8;
   localparam int DEF_CLKS_PER_BIT = 16;
endpackage

// File: rtl/serial_char_transmitter_if.sv
// serial_char_transmitter_if: character-source handshake and line outputs of the transmitter.
interface serial_char_transmitter_if
   import serial_link_pkg::*;
   #(parameter int DATA_BITS = DEF_DATA_BITS);
   logic                 enable;
   logic                 load;
   logic [DATA_BITS-1:0] charIn;
   logic                 serialOut;
   logic                 busy;
   logic                 bitSent;
   logic                 characterSent;
   modport master (output enable, load, charIn, input serialOut, busy, bitSent, characterSent);
   modport slave  (input enable, load, charIn, output serialOut, busy, bitSent, characterSent);
endinterface

// File: rtl/bit_period_timer.sv
// bit_period_timer: counts clocks within one bit time while run is high and
// flags the last (and next-to-last) cycle of each bit period.
module bit_period_timer
   import serial_link_pkg::*;
   #(parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT)
   (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic period_done,
   output logic period_pre_done
);
   localparam int TW = $clog2(CLKS_PER_BIT);
   logic [TW-1:0] tick_q, tick_d;
   assign period_done     = tick_q == TW'(CLKS_PER_BIT - 1);
   assign period_pre_done = tick_q == TW'(CLKS_PER_BIT - 2);
   always_comb tick_d = (!run || period_done) ? '0 : tick_q + TW'(1);
   always_ff @(posedge clk or negedge reset)
      if (!reset) tick_q <= '0;
      else        tick_q <= tick_d;
endmodule

// File: rtl/serial_char_transmitter.sv
// serial_char_transmitter: frames a parallel character as start, LSB-first data
// and stop bits on a registered serial line, each bit held CLKS_PER_BIT clocks.
module serial_char_transmitter
   import serial_link_pkg::*;
   #(
   parameter int DATA_BITS    = DEF_DATA_BITS,
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
   )
   (
   input logic                      clk,
   input logic                      reset,
   serial_char_transmitter_if.slave bus
);
   localparam int BW = $clog2(DATA_BITS) + 1;
   state_t               state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d, shift_nx;
   logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
   logic                 ser_q, ser_d;
   logic                 busy_q, busy_d;
   logic                 bit_sent_q, bit_sent_d;
   logic                 char_sent_q, char_sent_d;
   logic                 period_done, period_pre_done;
   bit_period_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .clk             (clk),
      .reset           (reset),
      .run             (bus.enable && state_q != IDLE),
      .period_done     (period_done),
      .period_pre_done (period_pre_done)
   );
   assign shift_nx = shift_q >> 1;
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      ser_d       = ser_q;
      busy_d      = busy_q;
      // bitSent is registered, so it is raised one cycle ahead of the bit's last clock
      bit_sent_d  = bus.enable && state_q == DATA && period_pre_done;
      char_sent_d = 1'b0;
      if (!bus.enable) begin
         state_d = IDLE;
         ser_d   = IDLE_LEVEL;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: if (bus.load) begin
               shift_d = bus.charIn;
               state_d = START;
               ser_d   = START_LEVEL;
               busy_d  = 1'b1;
            end
            START: if (period_done) begin
               state_d   = DATA;
               ser_d     = shift_q[0];
               bit_cnt_d = '0;
            end
            DATA: if (period_done) begin
               shift_d   = shift_nx;
               bit_cnt_d = bit_cnt_q + BW'(1);
               state_d   = (bit_cnt_q == BW'(DATA_BITS - 1)) ? STOP : DATA;
               ser_d     = (bit_cnt_q == BW'(DATA_BITS - 1)) ? STOP_LEVEL : shift_nx[0];
            end
            STOP: if (period_done) begin
               state_d     = IDLE;
               busy_d      = 1'b0;
               char_sent_d = 1'b1;
            end
         endcase
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         ser_q       <= IDLE_LEVEL;
         busy_q      <= 1'b0;
         bit_sent_q  <= 1'b0;
         char_sent_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         ser_q       <= ser_d;
         busy_q      <= busy_d;
         bit_sent_q  <= bit_sent_d;
         char_sent_q <= char_sent_d;
      end
   end
   assign bus.serialOut     = ser_q;
   assign bus.busy          = busy_q;
   assign bus.bitSent       = bit_sent_q;
   assign bus.characterSent = char_sent_q;
endmodule

// File: tb/tb_serial_char_transmitter.sv
// tb_serial_char_transmitter: directed frames on a default (8/16) and a small (7/4)
// transmitter, checking line timing, pulses, handshake, abort and async reset.
module tb_serial_char_transmitter;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;
   always #5 clk = ~clk;
   serial_char_transmitter_if #(.DATA_BITS(8)) b0 ();
   serial_char_transmitter_if #(.DATA_BITS(7)) b1 ();
   serial_char_transmitter #(.DATA_BITS(8), .CLKS_PER_BIT(16)) u_dut0 (.clk(clk), .reset(reset), .bus(b0));
   serial_char_transmitter #(.DATA_BITS(7), .CLKS_PER_BIT(4))  u_dut1 (.clk(clk), .reset(reset), .bus(b1));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask
   // Entered at the negedge right after the accepting edge; leaves in the characterSent cycle.
   task automatic watch(input bit sel, input logic [7:0] ch, input bit disturb, input string tag);
      int nb, cp, len, b, t;
      int n_bs, bad_bs, bad_busy, bad_cs;
      logic [31:0] exp_w, first_w, last_w;
      logic line, bs, bsy, cs;
      nb = sel ? 7 : 8;
      cp = sel ? 4 : 16;
      len = (nb + 2) * cp;
      exp_w = (32'd1 << (nb + 1)) | (32'(ch) << 1);
      first_w = '0;
      last_w = '0;
      n_bs = 0;
      bad_bs = 0;
      bad_busy = 0;
      bad_cs = 0;
      for (int j = 0; j < len; j++) begin
         b = j / cp;
         t = j % cp;
         line = sel ? b1.serialOut : b0.serialOut;
         bs = sel ? b1.bitSent : b0.bitSent;
         bsy = sel ? b1.busy : b0.busy;
         cs = sel ? b1.characterSent : b0.characterSent;
         if (t == 0) first_w[b] = line;
         if (t == cp - 1) last_w[b] = line;
         if (bs) n_bs++;
         if (bs != (b >= 1 && b <= nb && t == cp - 1)) bad_bs++;
         if (!bsy) bad_busy++;
         if (cs) bad_cs++;
         if (disturb) begin
            b0.load = (j == 40) || (j >= 100 && j < 110);
            if (j == 40) b0.charIn = 8'h00;
         end
         tick();
      end
      check({tag, " line at bit start"}, first_w, exp_w);
      check({tag, " line at bit end"}, last_w, exp_w);
      check({tag, " bitSent count"}, n_bs, nb);
      check({tag, " bitSent misplaced"}, bad_bs, 0);
      check({tag, " busy dropped"}, bad_busy, 0);
      check({tag, " early characterSent"}, bad_cs, 0);
      check({tag, " characterSent"}, sel ? b1.characterSent : b0.characterSent, 1);
      check({tag, " busy after frame"}, sel ? b1.busy : b0.busy, 0);
      check({tag, " line after frame"}, sel ? b1.serialOut : b0.serialOut, 1);
   endtask
   initial begin
      int quiet;
      b0.enable = 1'b1; b0.load = 1'b0; b0.charIn = '0;
      b1.enable = 1'b1; b1.load = 1'b0; b1.charIn = '0;
      repeat (3) @(negedge clk);
      check("reset line", b0.serialOut, 1);
      check("reset busy", b0.busy, 0);
      check("reset bitSent", b0.bitSent, 0);
      check("reset characterSent", b0.characterSent, 0);
      check("reset line small", b1.serialOut, 1);
      reset = 1'b1;
      tick();
      check("idle line", b0.serialOut, 1);
      check("idle busy", b0.busy, 0);
      b0.charIn = 8'hA5; b0.load = 1'b1;
      tick();
      b0.load = 1'b0;
      watch(1'b0, 8'hA5, 1'b0, "A5");
      tick();
      b0.charIn = 8'hFF; b0.load = 1'b1;
      tick();
      b0.load = 1'b0;
      watch(1'b0, 8'hFF, 1'b0, "FF");
      b0.charIn = 8'h3C; b0.load = 1'b1;
      tick();
      b0.load = 1'b0;
      watch(1'b0, 8'h3C, 1'b0, "3C b2b");
      tick();
      b0.charIn = 8'h81; b0.load = 1'b1;
      tick();
      b0.load = 1'b0;
      watch(1'b0, 8'h81, 1'b1, "81 disturbed");
      tick();
      b0.charIn = 8'h96; b0.load = 1'b1;
      tick();
      b0.load = 1'b0;
      repeat (69) tick();
      check("pre-abort line", b0.serialOut, 0);
      check("pre-abort busy", b0.busy, 1);
      b0.enable = 1'b0;
      tick();
      check("abort line", b0.serialOut, 1);
      check("abort busy", b0.busy, 0);
      check("abort characterSent", b0.characterSent, 0);
      b0.charIn = 8'h5A; b0.load = 1'b1;
      quiet = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (b0.busy || b0.characterSent || !b0.serialOut) quiet++;
      end
      check("disabled load ignored", quiet, 0);
      b0.enable = 1'b1;
      tick();
      b0.load = 1'b0;
      watch(1'b0, 8'h5A, 1'b0, "5A after abort");
      tick();
      b0.charIn = 8'hC3; b0.load = 1'b1;
      tick();
      b0.load = 1'b0;
      repeat (50) tick();
      check("pre-reset line", b0.serialOut, 0);
      #2 reset = 1'b0;
      #1;
      check("async reset line", b0.serialOut, 1);
      check("async reset busy", b0.busy, 0);
      check("async reset bitSent", b0.bitSent, 0);
      check("async reset characterSent", b0.characterSent, 0);
      @(negedge clk);
      reset = 1'b1;
      quiet = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (b0.busy || b0.characterSent || b0.bitSent || !b0.serialOut) quiet++;
      end
      check("no resume after reset", quiet, 0);
      b1.charIn = 7'h55; b1.load = 1'b1;
      tick();
      b1.load = 1'b0;
      watch(1'b1, 8'h55, 1'b0, "small 55");
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
